// File: rtl/seq_detect_pkg.sv
// Shared state type, default widths and pattern-length check for the
// seq_detect run controller and its window matcher.
package seq_detect_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TO_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A pattern length is usable only when it lies in 1..max_len.
  function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Sliding bit window with fill tracking; raises a combinational candidate
// when the stored bits plus the incoming bit equal the masked pattern.
module seq_window_match
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               shift,
  input  logic               match_clr,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               cand
);

  // Only the last len-1 received bits ever take part in a compare.
  logic [MAX_LEN-2:0] win_r;
  logic [LEN_W-1:0]   fill_r;
  logic [MAX_LEN-1:0] cmp_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               fill_ok_s;

  // Compare vector (newest bit at [0]) and the mask of active pattern bits
  always_comb begin
    cmp_s  = {win_r, bit_in};
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len));
    end
  end

  assign fill_ok_s = ({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len};
  assign cand      = fill_ok_s && (((cmp_s ^ pattern) & mask_s) == '0);

  // Window shift and fill count; the fill saturates at the pattern length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_r  <= '0;
      fill_r <= '0;
    end else if (clear) begin
      fill_r <= '0;
    end else if (shift) begin
      win_r <= cmp_s[MAX_LEN-2:0];
      if (match_clr) begin
        fill_r <= '0;
      end else if (fill_r < len) begin
        fill_r <= fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector.
// Optional run timeout enabled by defining SEQ_DETECT_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_target,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  input  logic [TO_W-1:0]              cfg_timeout,
  output logic                         timeout,
`endif
  input  logic                         start,
  input  logic                         abort,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_r, state_s;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   tgt_r, cnt_r, cnt_inc_s;
  logic               busy_r, done_r;
  logic               run_s, run_entry_s, cand_s, match_s, to_hit_s, len_ok_s;

  assign run_s       = (state_r == RUN);
  assign len_ok_s    = len_valid(32'(len_r), MAX_LEN);
  assign match_s     = run_s && bit_valid && !abort && cand_s;
  assign run_entry_s = !run_s && (state_s == RUN);
  assign cnt_inc_s   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  seq_window_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_win (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (run_entry_s),
    .shift     (run_s && bit_valid && !abort),
    .match_clr (match_s && !ovl_r),
    .bit_in    (bit_in),
    .pattern   (pat_r),
    .len       (len_r),
    .cand      (cand_s)
  );

  // Next-state: abort first, then target completion, then timeout
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (abort) state_s = IDLE;
        else if (start && len_ok_s) state_s = RUN;
        else state_s = state_r;
      end
      RUN: begin
        if (abort) state_s = IDLE;
        else if (match_s && (tgt_r != '0) && (cnt_inc_s == tgt_r)) state_s = DONE;
        else if (to_hit_s && !match_s) state_s = DONE;
        else state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pat_r   <= '0;
      len_r   <= '0;
      ovl_r   <= 1'b0;
      tgt_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (cfg_we && !run_s) begin
        pat_r <= cfg_pattern;
        len_r <= cfg_len;
        ovl_r <= cfg_overlap;
        tgt_r <= cfg_target;
      end
      if (run_entry_s) cnt_r <= '0;
      else if (match_s) cnt_r <= cnt_inc_s;
    end
  end

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_r, to_cnt_r;
  logic            timeout_r;

  assign to_hit_s = run_s && bit_valid && !abort && (to_r != '0) &&
                    ((to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1}) == to_r);

  // Timeout limit, valid-bit counter since the last match, and end-of-run flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_r      <= '0;
      to_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (cfg_we && !run_s) to_r <= cfg_timeout;
      if (run_entry_s || match_s) to_cnt_r <= '0;
      else if (run_s && bit_valid && !abort) to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      if (run_entry_s) timeout_r <= 1'b0;
      else if (run_s && (state_s == DONE) && to_hit_s && !match_s) timeout_r <= 1'b1;
    end
  end

  assign timeout = timeout_r;
`else
  assign to_hit_s = 1'b0;
`endif

  assign match     = match_s;
  assign match_cnt = cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for a programmable serial pattern detector. It holds a software-written pattern configuration and sequences detection runs (start, abort, completion). It contains the sliding-window matcher as a sub-module, counts matches, and signals completion when a target match count is reached. It sits between the configuration/control path and the serial bit stream that fixed-pattern Mealy detectors (for example the 0110 detector) consume today.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits.
- `CNT_W`, default 8: width of the match counter and target.
- `TO_W`, default 16: width of the timeout counter (used only with the timeout feature).

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `[cfg_len-1]` is received first, bit `[0]` last.
- `cfg_len`  in  $clog2(MAX_LEN+1)  pattern length; valid range is 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = window restarts after each match.
- `cfg_target`  in  CNT_W  number of matches that ends a run; 0 = unlimited.
- `cfg_timeout`  in  TO_W  timeout limit in bit_valid cycles; 0 = disabled. Present only with the macro.
- `start`  in  1  begin a run (single-cycle strobe).
- `abort`  in  1  terminate a run.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  serial data bit.
- `match`  out  1  Mealy pulse: asserted in the cycle whose valid bit completes the pattern.
- `match_cnt`  out  CNT_W  matches counted in the current or last run; saturates at the maximum value.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  the run ended on timeout. Present only with the macro.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE and clears `match`, `match_cnt`, `busy`, `done`, `timeout`, the config registers and the window.
- Config registers load on `cfg_we` in IDLE or DONE. `cfg_we` is ignored in RUN.
- IDLE/DONE → RUN on `start`, provided the registered length is in 1..MAX_LEN. Entering RUN clears `match_cnt`, the window fill count and `timeout`. With an invalid length, `start` is ignored and the state is unchanged.
- In RUN, each `bit_valid` shifts `bit_in` into the window and increments the fill count, which saturates at `cfg_len`.
- `match` is combinational: RUN && `bit_valid` && !`abort` && fill ≥ `cfg_len`−1 && (last `cfg_len`−1 stored bits, then `bit_in`) == `cfg_pattern[cfg_len-1:0]`.
- On `match`:
  - `match_cnt` increments.
  - If `cfg_overlap`=0, the fill count is cleared so the next match needs `cfg_len` fresh bits. If `cfg_overlap`=1, the window keeps its contents.
- RUN → DONE at the clock edge where a `match` brings `match_cnt` to equal a nonzero `cfg_target`.
- RUN → IDLE on `abort`. `abort` takes priority over a same-cycle match: `match` is masked and the count is not incremented. `match_cnt` is retained.
- `abort` in IDLE or DONE → IDLE.
- `start` in RUN is ignored.
- DONE holds `done` and `match_cnt` until `start` or `abort`.
- Cycles with `bit_valid`=0 leave the window and counters unchanged.

## Timing
- `match` has zero latency: same cycle as the completing bit.
- `match_cnt` updates one clock after `match`.
- `busy` rises the clock after `start`.
- `done` rises the clock after the final `match`.
- Throughput is one bit per clock; there is no backpressure.
- An asynchronous reset mid-run returns the block to the IDLE reset state immediately. There is no partial state.

## Configuration
- `SEQ_DETECT_CTRL_TIMEOUT_EN`.
- Defined:
  - Adds the `cfg_timeout` port (registered on `cfg_we`), the `timeout` port and a TO_W-bit counter.
  - The counter clears on entry to RUN and on each `match`, and increments on each `bit_valid` in RUN.
  - When it reaches a nonzero `cfg_timeout`, the FSM goes RUN → DONE with `timeout`=1. A match in that same cycle takes priority: the counter clears and the run continues.
- Undefined: neither port nor the counter exists, and RUN ends only on target or abort.

## Structure
- Package `seq_detect_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default widths;
  - a length-validity function.
- Sub-module `seq_window_match` holds the MAX_LEN shift window, the fill counter, the masked compare and the overlap clear. It outputs a combinational match-candidate signal.
- The controller owns the FSM, the config registers, the counters and the gating of `match`.

## Test plan
- Pattern 0110, length 4, overlap=1, target=0; stream 0,1,1,0,1,1,0 → `match` on bits 4 and 7; `match_cnt`=2.
- Same stream with overlap=0 → `match` on bit 4 only; `match_cnt`=1.
- Pattern 101, length 3, target=2; stream 1,0,1,0,1 → `done` one clock after bit 5, `busy` low; later bits give no `match`.
- `abort` asserted in the same cycle as a completing bit → `match`=0, `match_cnt` unchanged, state IDLE next clock.
- `cfg_len`=0 or MAX_LEN+1, then `start` → `busy` stays 0. `cfg_we` during RUN → the old pattern is still matched.
- With the macro, `cfg_timeout`=5 and no matches for 5 valid bits → `done`=1 and `timeout`=1. Reset mid-run → all outputs 0 immediately.
